// File: rtl/gf180_ram_wb_bridge.sv
// gf180_ram_wb_bridge
//   Wishbone classic slave fronting one 64x8 GF180 SRAM macro. A 32-bit
//   bus word is serialised into four byte accesses on the macro; writes
//   skip lanes whose byte select is clear, reads always fetch all four bytes.
//
// Ports
//   wb_clk_i, wb_rst_i    clock (shared with the macro) and sync active-high reset
//   wbs_cyc_i, wbs_stb_i  bus cycle / strobe
//   wbs_we_i, wbs_sel_i   direction and byte-lane selects
//   wbs_adr_i, wbs_dat_i  byte address ([5:2] = word index) and write data
//   wbs_ack_o, wbs_dat_o  registered one-cycle ack and registered read data
//   ram_cen/gwen/wen      macro controls, active low
//   ram_a, ram_d, ram_q   macro byte address, write data, read data
module gf180_ram_wb_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [31:0] ADDR_MASK = 32'hFFFF_FFC0
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        ram_cen,
  output logic        ram_gwen,
  output logic [7:0]  ram_wen,
  output logic [5:0]  ram_a,
  output logic [7:0]  ram_d,
  input  logic [7:0]  ram_q
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DRAIN,
    S_ACK
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic        ack_q, ack_d;
  logic [31:0] rdat_q, rdat_d;

  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [3:0]  word_q, word_d;
  logic [31:0] wdat_q, wdat_d;
  logic [23:0] rbuf_q, rbuf_d;

  logic hit;
  logic req;

  assign hit = ((wbs_adr_i & ADDR_MASK) == BASE_ADDR);
  assign req = wbs_cyc_i & wbs_stb_i & hit;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ack_d   = 1'b0;
    rdat_d  = rdat_q;
    we_d    = we_q;
    sel_d   = sel_q;
    word_d  = word_q;
    wdat_d  = wdat_q;
    rbuf_d  = rbuf_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          we_d    = wbs_we_i;
          sel_d   = wbs_sel_i;
          word_d  = wbs_adr_i[5:2];
          wdat_d  = wbs_dat_i;
          idx_d   = 2'd0;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (!wbs_cyc_i) begin
          // Abort: lanes already issued to the macro stay written.
          state_d = S_IDLE;
          idx_d   = 2'd0;
        end else begin
          // Q lags the sampled address by one edge, so it holds byte idx-1.
          if (!we_q) begin
            case (idx_q)
              2'd1:    rbuf_d[7:0]   = ram_q;
              2'd2:    rbuf_d[15:8]  = ram_q;
              2'd3:    rbuf_d[23:16] = ram_q;
              default: ;
            endcase
          end
          if (idx_q == 2'd3) begin
            idx_d = 2'd0;
            if (we_q) begin
              state_d = S_ACK;
              ack_d   = 1'b1;
            end else begin
              state_d = S_DRAIN;
            end
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      S_DRAIN: begin
        if (!wbs_cyc_i) begin
          state_d = S_IDLE;
        end else begin
          rdat_d  = {ram_q, rbuf_q};
          ack_d   = 1'b1;
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        // Any request still present here is the one just served; drop it.
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      idx_q   <= 2'd0;
      ack_q   <= 1'b0;
      rdat_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ack_q   <= ack_d;
      rdat_q  <= rdat_d;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    we_q   <= we_d;
    sel_q  <= sel_d;
    word_q <= word_d;
    wdat_q <= wdat_d;
    rbuf_q <= rbuf_d;
  end

  // Macro pins decode from registered state only, so they are glitch-free
  // relative to the shared clock edge.
  always_comb begin
    ram_cen  = 1'b1;
    ram_gwen = 1'b1;
    ram_wen  = 8'hFF;
    ram_a    = {word_q, idx_q};
    ram_d    = wdat_q[{idx_q, 3'b000} +: 8];
    if (state_q == S_ACCESS) begin
      if (!we_q) begin
        ram_cen = 1'b0;
      end else if (sel_q[idx_q]) begin
        ram_cen  = 1'b0;
        ram_gwen = 1'b0;
        ram_wen  = 8'h00;
      end
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = rdat_q;

endmodule

// File: tb/tb_gf180_ram_wb_bridge.sv
// Testbench for gf180_ram_wb_bridge: behavioural 64x8 macro with registered
// Q, table-driven directed vectors, abort/reset sequences, and randomized
// traffic checked against a byte-array reference of the RAM contents.
module tb_gf180_ram_wb_bridge;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk;
  logic        rst;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat_w;
  logic        ack;
  logic [31:0] dat_r;
  logic        ram_cen, ram_gwen;
  logic [7:0]  ram_wen, ram_d, ram_q;
  logic [5:0]  ram_a;

  gf180_ram_wb_bridge #(.BASE_ADDR(BASE), .ADDR_MASK(32'hFFFF_FFC0)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wbs_cyc_i(cyc),
    .wbs_stb_i(stb),
    .wbs_we_i (we),
    .wbs_sel_i(sel),
    .wbs_adr_i(adr),
    .wbs_dat_i(dat_w),
    .wbs_ack_o(ack),
    .wbs_dat_o(dat_r),
    .ram_cen  (ram_cen),
    .ram_gwen (ram_gwen),
    .ram_wen  (ram_wen),
    .ram_a    (ram_a),
    .ram_d    (ram_d),
    .ram_q    (ram_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Macro model: bit-masked write, registered read data.
  logic [7:0] mem [0:63];
  always @(posedge clk) begin
    if (ram_cen === 1'b0) begin
      if (ram_gwen === 1'b0)
        mem[ram_a] <= (mem[ram_a] & ram_wen) | (ram_d & ~ram_wen);
      else
        ram_q <= mem[ram_a];
    end
  end

  int inv_err = 0;
  always @(negedge clk) begin
    if (ram_gwen === 1'b0 && ram_cen !== 1'b0) inv_err++;
  end

  // Reference contents of the RAM, as bytes.
  logic [7:0] ref_mem [0:63];
  logic [31:0] exp_dat_o;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic ref_write(input logic [3:0] word, input logic [3:0] s, input logic [31:0] d, input int nlanes);
    for (int i = 0; i < nlanes; i++)
      if (s[i]) ref_mem[word*4 + i] = d[8*i +: 8];
  endtask

  function automatic logic [31:0] ref_read(input logic [3:0] word);
    return {ref_mem[word*4+3], ref_mem[word*4+2], ref_mem[word*4+1], ref_mem[word*4]};
  endfunction

  function automatic logic [63:0] lane_mask(input logic [3:0] word, input logic [3:0] s);
    logic [63:0] m;
    m = 64'd0;
    for (int i = 0; i < 4; i++)
      if (s[i]) m[word*4 + i] = 1'b1;
    return m;
  endfunction

  // One bus transaction; waits at most 20 cycles for the ack.
  task automatic run_req(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                         output logic got_ack, output int lat, output logic [31:0] rd,
                         output logic [63:0] wmask, output logic [63:0] rmask);
    logic [63:0] wm, rm;
    wm = 64'd0; rm = 64'd0; got_ack = 1'b0; lat = 0;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = a; dat_w = d;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (ram_cen === 1'b0) begin
        if (ram_gwen === 1'b0) wm[ram_a] = 1'b1;
        else rm[ram_a] = 1'b1;
      end
      if (ack === 1'b1) begin
        got_ack = 1'b1; lat = c;
        break;
      end
    end
    rd = dat_r;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    if (got_ack) begin
      @(posedge clk); #1;
    end
    wmask = wm; rmask = rm;
  endtask

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic        exp_ack;
    int          exp_lat;
    logic [31:0] exp_rd;
    logic [63:0] exp_wm;
    logic [63:0] exp_rm;
  } vec_t;

  vec_t tbl [9];

  initial begin
    logic        ga;
    int          lat, acks, acc, first_lat;
    logic [31:0] rd;
    logic [63:0] wm, rm;

    tbl[0] = '{1'b1, BASE+32'h0C, 4'hF, 32'hDEADBEEF, 1'b1, 5, 32'h0, 64'h0000_0000_0000_F000, 64'h0};
    tbl[1] = '{1'b0, BASE+32'h0C, 4'hF, 32'h0,        1'b1, 6, 32'hDEADBEEF, 64'h0, 64'h0000_0000_0000_F000};
    tbl[2] = '{1'b1, BASE+32'h0C, 4'h4, 32'h00AA0000, 1'b1, 5, 32'h0, 64'h0000_0000_0000_4000, 64'h0};
    tbl[3] = '{1'b0, BASE+32'h0C, 4'hF, 32'h0,        1'b1, 6, 32'hDEAABEEF, 64'h0, 64'h0000_0000_0000_F000};
    tbl[4] = '{1'b1, BASE+32'h3C, 4'hF, 32'h01234567, 1'b1, 5, 32'h0, 64'hF000_0000_0000_0000, 64'h0};
    tbl[5] = '{1'b0, BASE+32'h3C, 4'hF, 32'h0,        1'b1, 6, 32'h01234567, 64'h0, 64'hF000_0000_0000_0000};
    tbl[6] = '{1'b0, BASE+32'h00, 4'hF, 32'h0,        1'b1, 6, 32'hA5A5A5A5, 64'h0, 64'h0000_0000_0000_000F};
    tbl[7] = '{1'b1, BASE+32'h40, 4'hF, 32'h12345678, 1'b0, 0, 32'h0, 64'h0, 64'h0};
    tbl[8] = '{1'b0, BASE+32'h40, 4'hF, 32'h0,        1'b0, 0, 32'h0, 64'h0, 64'h0};

    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = 32'h0; dat_w = 32'h0;
    exp_dat_o = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_ack", {63'd0, ack}, 64'd0);
    check("rst_dat", {32'd0, dat_r}, 64'd0);
    check("rst_cen", {63'd0, ram_cen}, 64'd1);
    check("rst_gwen", {63'd0, ram_gwen}, 64'd1);
    check("rst_wen", {56'd0, ram_wen}, 64'hFF);

    // Preload every word with a known pattern
    for (int w = 0; w < 16; w++) begin
      logic [31:0] pv;
      pv = {4{8'(w)}} ^ 32'hA5A5A5A5;
      run_req(1'b1, BASE + 32'(w*4), 4'hF, pv, ga, lat, rd, wm, rm);
      ref_write(4'(w), 4'hF, pv, 4);
      check($sformatf("preload%0d_lat", w), 64'(lat), 64'd5);
    end

    // Directed vectors
    for (int i = 0; i < 9; i++) begin
      run_req(tbl[i].we, tbl[i].adr, tbl[i].sel, tbl[i].dat, ga, lat, rd, wm, rm);
      check($sformatf("vec%0d_ack", i), {63'd0, ga}, {63'd0, tbl[i].exp_ack});
      check($sformatf("vec%0d_lat", i), 64'(lat), 64'(tbl[i].exp_lat));
      check($sformatf("vec%0d_wmask", i), wm, tbl[i].exp_wm);
      check($sformatf("vec%0d_rmask", i), rm, tbl[i].exp_rm);
      if (tbl[i].exp_ack && !tbl[i].we) begin
        check($sformatf("vec%0d_rdata", i), {32'd0, rd}, {32'd0, tbl[i].exp_rd});
        exp_dat_o = tbl[i].exp_rd;
      end
      if (tbl[i].exp_ack && tbl[i].we)
        ref_write(tbl[i].adr[5:2], tbl[i].sel, tbl[i].dat, 4);
    end

    // Abort a write by dropping cyc on the edge that leaves lane 1
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = BASE + 32'h14; dat_w = 32'h11223344;
    @(posedge clk); #1;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    ref_write(4'd5, 4'hF, 32'h11223344, 2);
    acks = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (ack === 1'b1) acks++;
    end
    check("abort_noack", 64'(acks), 64'd0);
    check("abort_dat_hold", {32'd0, dat_r}, {32'd0, exp_dat_o});
    run_req(1'b0, BASE + 32'h14, 4'hF, 32'h0, ga, lat, rd, wm, rm);
    check("abort_partial", {32'd0, rd}, {32'd0, ref_read(4'd5)});
    check("abort_partial_const", {32'd0, rd}, 64'hA0A0_3344);
    exp_dat_o = ref_read(4'd5);

    // Same sequence, reset instead of abort
    run_req(1'b1, BASE + 32'h14, 4'hF, 32'hA0A0A0A0, ga, lat, rd, wm, rm);
    ref_write(4'd5, 4'hF, 32'hA0A0A0A0, 4);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = BASE + 32'h14; dat_w = 32'h11223344;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    ref_write(4'd5, 4'hF, 32'h11223344, 2);
    exp_dat_o = 32'h0;
    check("rstmid_ack", {63'd0, ack}, 64'd0);
    check("rstmid_dat", {32'd0, dat_r}, 64'd0);
    check("rstmid_cen", {63'd0, ram_cen}, 64'd1);
    run_req(1'b0, BASE + 32'h14, 4'hF, 32'h0, ga, lat, rd, wm, rm);
    check("rstmid_partial", {32'd0, rd}, 64'hA0A0_3344);
    exp_dat_o = rd;

    // Read with the request held past the ack
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = BASE + 32'h0C;
    acks = 0; acc = 0; first_lat = 0;
    for (int c = 1; c <= 14; c++) begin
      @(posedge clk); #1;
      if (ram_cen === 1'b0) acc++;
      if (ack === 1'b1) begin
        acks++;
        if (first_lat == 0) first_lat = c;
      end
      if (first_lat != 0 && c == first_lat + 1) stb = 1'b0;
      if (first_lat != 0 && c == first_lat + 2) cyc = 1'b0;
    end
    cyc = 1'b0; stb = 1'b0;
    check("hold_acks", 64'(acks), 64'd1);
    check("hold_lat", 64'(first_lat), 64'd6);
    check("hold_accesses", 64'(acc), 64'd4);
    check("hold_rdata", {32'd0, dat_r}, {32'd0, ref_read(4'd3)});
    exp_dat_o = ref_read(4'd3);

    // Randomized traffic against the reference
    for (int n = 0; n < 40; n++) begin
      logic        rw, miss;
      logic [3:0]  wd, s;
      logic [31:0] d, a;
      rw   = 1'($urandom);
      wd   = 4'($urandom_range(0, 15));
      s    = 4'($urandom);
      d    = $urandom;
      miss = ($urandom_range(0, 7) == 0);
      a    = miss ? (32'h3000_0040 | ($urandom & 32'h0000_0FFC)) : (BASE | {26'd0, wd, 2'($urandom)});
      run_req(rw, a, s, d, ga, lat, rd, wm, rm);
      if (miss) begin
        check($sformatf("rnd%0d_miss_ack", n), {63'd0, ga}, 64'd0);
        check($sformatf("rnd%0d_miss_pins", n), wm | rm, 64'd0);
      end else if (rw) begin
        check($sformatf("rnd%0d_wlat", n), 64'(lat), 64'd5);
        check($sformatf("rnd%0d_wmask", n), wm, lane_mask(wd, s));
        ref_write(wd, s, d, 4);
      end else begin
        check($sformatf("rnd%0d_rlat", n), 64'(lat), 64'd6);
        check($sformatf("rnd%0d_rmask", n), rm, lane_mask(wd, 4'hF));
        check($sformatf("rnd%0d_rdata", n), {32'd0, rd}, {32'd0, ref_read(wd)});
        exp_dat_o = ref_read(wd);
      end
    end
    check("final_dat_hold", {32'd0, dat_r}, {32'd0, exp_dat_o});
    check("gwen_only_with_cen", 64'(inv_err), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", pass_cnt, total_cnt);
    $fatal(1, "timeout");
  end

endmodule
